// File: rtl/spm_fetch.sv
// Instruction-fetch front end for the scratchpad: owns the PC, issues one SPM read per cycle and
// re-times the returning word onto {if_pc, if_insn, if_en}. Define SPM_FETCH_PERF_EN to add fetch_cnt.
module spm_fetch #(
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
`ifdef SPM_FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt
`endif
);

  localparam logic READ     = 1'b1;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              hold_v_q, hold_v_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [DATA_W-1:0] hold_insn_q, hold_insn_d;
  logic              if_en_q, if_en_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_insn_q, if_insn_d;
  logic              issue;

  assign issue       = rst_n & ~flush & ~stall;
  assign spm_addr    = pc_q;
  assign spm_as_     = issue ? ENABLE_ : DISABLE_;
  assign spm_rw      = READ;
  assign spm_wr_data = '0;
  assign if_pc       = if_pc_q;
  assign if_insn     = if_insn_q;
  assign if_en       = if_en_q;

  always_comb begin
    pc_d        = pc_q;
    pend_d      = 1'b0;
    pend_pc_d   = pend_pc_q;
    hold_v_d    = hold_v_q;
    hold_pc_d   = hold_pc_q;
    hold_insn_d = hold_insn_q;
    if_en_d     = if_en_q;
    if_pc_d     = if_pc_q;
    if_insn_d   = if_insn_q;
    if (flush) begin
      pc_d     = new_pc;
      hold_v_d = 1'b0;
      if_en_d  = 1'b0;
    end else if (stall) begin
      // the word landing this cycle has nowhere to go but the single hold slot
      if (pend_q) begin
        hold_pc_d   = pend_pc_q;
        hold_insn_d = spm_rd_data;
        hold_v_d    = 1'b1;
      end
    end else begin
      pc_d      = pc_q + ADDR_W'(1);
      pend_d    = 1'b1;
      pend_pc_d = pc_q;
      if (hold_v_q) begin
        if_en_d   = 1'b1;
        if_pc_d   = hold_pc_q;
        if_insn_d = hold_insn_q;
        hold_v_d  = 1'b0;
      end else if (pend_q) begin
        if_en_d   = 1'b1;
        if_pc_d   = pend_pc_q;
        if_insn_d = spm_rd_data;
      end else begin
        if_en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_pc_q   <= '0;
      hold_v_q    <= 1'b0;
      hold_pc_q   <= '0;
      hold_insn_q <= '0;
      if_en_q     <= 1'b0;
      if_pc_q     <= '0;
      if_insn_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      hold_v_q    <= hold_v_d;
      hold_pc_q   <= hold_pc_d;
      hold_insn_q <= hold_insn_d;
      if_en_q     <= if_en_d;
      if_pc_q     <= if_pc_d;
      if_insn_q   <= if_insn_d;
    end
  end

`ifdef SPM_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // if_en_d can only be 1 outside stall/flush when a fresh word is being loaded
  assign fetch_cnt_d = fetch_cnt_q + 32'(if_en_d & ~stall & ~flush);
  assign fetch_cnt   = fetch_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_cnt_q <= '0;
    else        fetch_cnt_q <= fetch_cnt_d;
  end
`endif

endmodule

// File: tb/tb_spm_fetch.sv
// Bench for spm_fetch: directed scenarios plus a random stall/flush run scored against a
// queue-based model of issued-but-undelivered words.
module tb_spm_fetch;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] new_pc = '0;

  logic [AW-1:0] a0, aw, pc0, pcw;
  logic          as0, asw, rw0, rww, en0, enw;
  logic [DW-1:0] wd0, wdw, rd0, rdw, insn0, insnw;
`ifdef SPM_FETCH_PERF_EN
  logic [31:0]   cnt0, cntw;
`endif

  logic [DW-1:0] mem [0:4095];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spm_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(12'd0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .new_pc(new_pc),
    .spm_addr(a0), .spm_as_(as0), .spm_rw(rw0), .spm_wr_data(wd0), .spm_rd_data(rd0),
    .if_pc(pc0), .if_insn(insn0), .if_en(en0)
`ifdef SPM_FETCH_PERF_EN
    , .fetch_cnt(cnt0)
`endif
  );

  spm_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(12'hFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .new_pc(new_pc),
    .spm_addr(aw), .spm_as_(asw), .spm_rw(rww), .spm_wr_data(wdw), .spm_rd_data(rdw),
    .if_pc(pcw), .if_insn(insnw), .if_en(enw)
`ifdef SPM_FETCH_PERF_EN
    , .fetch_cnt(cntw)
`endif
  );

  // SPM: data for a strobed read appears the following cycle; unstrobed cycles return junk
  always @(posedge clk) rd0 <= (as0 == 1'b0) ? mem[a0] : $urandom;
  always @(posedge clk) rdw <= (asw == 1'b0) ? mem[aw] : $urandom;

  // Model: every issued word is delivered once, in order, no earlier than the edge after
  // the one that issued it; a flush or reset discards everything outstanding.
  typedef struct { logic [AW-1:0] pc; int e; } ent_t;
  ent_t          q[$];
  logic [AW-1:0] pc_m = '0;
  logic          en_m = 1'b0;
  logic [AW-1:0] pcx_m = '0;
  logic [DW-1:0] insnx_m = '0;
  logic [31:0]   cnt_m = '0;
  int            edge_n = 0;

  initial begin
    logic exp_as;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        pc_m = '0; en_m = 1'b0; pcx_m = '0; insnx_m = '0; cnt_m = '0; edge_n = 0;
      end
      checks++;
      if (en0 !== en_m) begin
        failures++; $display("FAIL mon_if_en t=%0t got=%b exp=%b", $time, en0, en_m);
      end
      checks++;
      if (pc0 !== pcx_m || insn0 !== insnx_m) begin
        failures++;
        $display("FAIL mon_word t=%0t got=(%0d,%0d) exp=(%0d,%0d)", $time, pc0, insn0, pcx_m, insnx_m);
      end
      exp_as = !(rst_n && !flush && !stall);
      checks++;
      if (as0 !== exp_as || a0 !== pc_m) begin
        failures++;
        $display("FAIL mon_issue t=%0t got as_=%b addr=%0d exp as_=%b addr=%0d", $time, as0, a0, exp_as, pc_m);
      end
      checks++;
      if (rw0 !== 1'b1 || wd0 !== '0) begin
        failures++; $display("FAIL mon_rw t=%0t got rw=%b wd=%0h exp rw=1 wd=0", $time, rw0, wd0);
      end
`ifdef SPM_FETCH_PERF_EN
      checks++;
      if (cnt0 !== cnt_m) begin
        failures++; $display("FAIL mon_fetch_cnt t=%0t got=%0d exp=%0d", $time, cnt0, cnt_m);
      end
`endif
      if (rst_n) begin
        edge_n++;
        if (flush) begin
          q.delete();
          pc_m = new_pc;
          en_m = 1'b0;
        end else if (!stall) begin
          if (q.size() != 0 && q[0].e < edge_n) begin
            en_m = 1'b1;
            pcx_m = q[0].pc;
            insnx_m = mem[q[0].pc];
            cnt_m++;
            void'(q.pop_front());
          end else begin
            en_m = 1'b0;
          end
          q.push_back('{pc: pc_m, e: edge_n});
          pc_m = pc_m + 1'b1;
        end
      end
    end
  end

  task automatic cyc(input logic st, input logic fl, input logic [AW-1:0] np);
    @(posedge clk); #2;
    stall = st; flush = fl; new_pc = np;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, '0);
    checks++;
    if (en0 !== 1'b0 || pc0 !== '0 || insn0 !== '0) begin
      failures++; $display("FAIL reset_out got en=%b pc=%0d insn=%0d exp 0,0,0", en0, pc0, insn0);
    end
    checks++;
    if (as0 !== 1'b1 || asw !== 1'b1) begin
      failures++; $display("FAIL reset_as got %b/%b exp 1/1", as0, asw);
    end
    checks++;
    if (rw0 !== 1'b1 || wd0 !== '0) begin
      failures++; $display("FAIL reset_rw got rw=%b wd=%0h exp 1,0", rw0, wd0);
    end
  endtask

  task automatic test_stream();
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (as0 !== 1'b0 || a0 !== 12'd0) begin
      failures++; $display("FAIL stream_first_issue got as_=%b addr=%0d exp 0,0", as0, a0);
    end
    for (int k = 1; k <= 17; k++) begin
      cyc(1'b0, 1'b0, '0);
      checks++;
      if (a0 !== AW'(k)) begin
        failures++; $display("FAIL stream_addr k=%0d got=%0d exp=%0d", k, a0, k);
      end
      checks++;
      if (k < 2 && en0 !== 1'b0) begin
        failures++; $display("FAIL stream_latency k=%0d got en=%b exp 0", k, en0);
      end else if (k >= 2 && (en0 !== 1'b1 || pc0 !== AW'(k - 2) || insn0 !== DW'(257 - k))) begin
        failures++;
        $display("FAIL stream_word k=%0d got (%b,%0d,%0d) exp (1,%0d,%0d)", k, en0, pc0, insn0, k - 2, 257 - k);
      end
    end
  endtask

  task automatic test_stall();
    cyc(1'b0, 1'b1, 12'd0);
    repeat (5) cyc(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, '0);
      checks++;
      if (en0 !== 1'b1 || pc0 !== 12'd3 || insn0 !== 32'd252 || as0 !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold i=%0d got (%b,%0d,%0d) as_=%b exp (1,3,252) as_=1", i, en0, pc0, insn0, as0);
      end
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (en0 !== 1'b1 || pc0 !== 12'd3 || insn0 !== 32'd252) begin
      failures++; $display("FAIL stall_release got (%b,%0d,%0d) exp (1,3,252)", en0, pc0, insn0);
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (en0 !== 1'b1 || pc0 !== 12'd4 || insn0 !== 32'd251) begin
      failures++; $display("FAIL stall_resume got (%b,%0d,%0d) exp (1,4,251)", en0, pc0, insn0);
    end
  endtask

  task automatic test_flush();
    cyc(1'b0, 1'b1, 12'd10);
    checks++;
    if (en0 !== 1'b1 || pc0 !== 12'd5 || insn0 !== 32'd250) begin
      failures++; $display("FAIL flush_before got (%b,%0d,%0d) exp (1,5,250)", en0, pc0, insn0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, '0);
      checks++;
      if (en0 !== 1'b0) begin
        failures++; $display("FAIL flush_bubble i=%0d got en=%b pc=%0d exp en=0", i, en0, pc0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, '0);
      checks++;
      if (en0 !== 1'b1 || pc0 !== AW'(10 + i) || insn0 !== DW'(245 - i)) begin
        failures++;
        $display("FAIL flush_target i=%0d got (%b,%0d,%0d) exp (1,%0d,%0d)", i, en0, pc0, insn0, 10 + i, 245 - i);
      end
    end
  endtask

  task automatic test_flush_stall();
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 12'd2);
    cyc(1'b1, 1'b0, '0);
    checks++;
    if (en0 !== 1'b0) begin
      failures++; $display("FAIL flush_stall_en got=%b exp=0", en0);
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (en0 !== 1'b0 || as0 !== 1'b0 || a0 !== 12'd2) begin
      failures++; $display("FAIL flush_stall_issue got en=%b as_=%b addr=%0d exp 0,0,2", en0, as0, a0);
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (en0 !== 1'b0) begin
      failures++; $display("FAIL flush_stall_hold_cleared got en=%b pc=%0d exp en=0", en0, pc0);
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (en0 !== 1'b1 || pc0 !== 12'd2 || insn0 !== 32'd253) begin
      failures++; $display("FAIL flush_stall_first got (%b,%0d,%0d) exp (1,2,253)", en0, pc0, insn0);
    end
  endtask

  task automatic test_wrap();
    @(posedge clk); #2; rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk); #1;
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (aw !== 12'hFFF || asw !== 1'b0) begin
      failures++; $display("FAIL wrap_first_issue got addr=%0d as_=%b exp 4095,0", aw, asw);
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (aw !== 12'd0) begin
      failures++; $display("FAIL wrap_addr got=%0d exp=0", aw);
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (enw !== 1'b1 || pcw !== 12'hFFF || insnw !== mem[4095]) begin
      failures++; $display("FAIL wrap_top got (%b,%0d,%0h) exp (1,4095,%0h)", enw, pcw, insnw, mem[4095]);
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (enw !== 1'b1 || pcw !== 12'd0 || insnw !== 32'd255) begin
      failures++; $display("FAIL wrap_zero got (%b,%0d,%0d) exp (1,0,255)", enw, pcw, insnw);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    checks++;
    if (en0 !== 1'b0 || as0 !== 1'b1 || pc0 !== '0 || insn0 !== '0) begin
      failures++;
      $display("FAIL reset_mid_now got en=%b as_=%b pc=%0d insn=%0d exp 0,1,0,0", en0, as0, pc0, insn0);
    end
`ifdef SPM_FETCH_PERF_EN
    checks++;
    if (cnt0 !== 32'd0) begin
      failures++; $display("FAIL reset_mid_cnt got=%0d exp=0", cnt0);
    end
`endif
    @(negedge clk); #1;
    @(posedge clk); #2; rst_n = 1'b1; stall = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (as0 !== 1'b0 || a0 !== 12'd0) begin
      failures++; $display("FAIL reset_mid_restart got as_=%b addr=%0d exp 0,0", as0, a0);
    end
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (en0 !== 1'b1 || pc0 !== 12'd0 || insn0 !== 32'd255) begin
      failures++; $display("FAIL reset_mid_first got (%b,%0d,%0d) exp (1,0,255)", en0, pc0, insn0);
    end
  endtask

  task automatic test_random();
    logic st, fl;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(99) < 30);
      fl = ($urandom_range(99) < 6);
      cyc(st, fl, AW'($urandom));
      if (en0 === 1'b1) begin
        checks++;
        if (insn0 !== mem[pc0]) begin
          failures++; $display("FAIL random_insn i=%0d pc=%0d got=%0h exp=%0h", i, pc0, insn0, mem[pc0]);
        end
      end
    end
    repeat (4) cyc(1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = (i < 16) ? DW'(255 - i) : $urandom;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
